cycle_ctrl: RTL and testbench



---
 rtl/cycle_ctrl_if.sv | 30 +++
 rtl/cycle_ctrl.sv | 102 ++++++++++
 tb/tb_cycle_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_ctrl_if.sv
// Decoder/datapath-facing signal bundle of the instruction-cycle sequencer.
// master: decoder/flags side driving control, observing the cycle vector.
// slave : the sequencer itself.
interface cycle_ctrl_if #(
  parameter int unsigned COUNT_WIDTH = 16
) ();

  logic                   run;
  logic                   step;
  logic                   is_mul;
  logic                   is_halt;
  logic                   branch_req;
  logic [2:0]             cycle;
  logic                   branch;
  logic                   mul_busy;
  logic                   busy;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output run, step, is_mul, is_halt, branch_req,
    input  cycle, branch, mul_busy, busy, halted, instr_count
  );

  modport slave (
    input  run, step, is_mul, is_halt, branch_req,
    output cycle, branch, mul_busy, busy, halted, instr_count
  );

endinterface

// File: rtl/cycle_ctrl.sv
// Instruction-cycle sequencer for the picoMIPS core: one-hot FETCH/DECODE/EXEC
// vector, multiply wait states, run/step/halt control and a retired counter.
module cycle_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,   // legal range 1..15
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  cycle_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = 4;

  localparam logic [2:0] CYC_NONE   = 3'b000;
  localparam logic [2:0] CYC_FETCH  = 3'b001;
  localparam logic [2:0] CYC_DECODE = 3'b010;
  localparam logic [2:0] CYC_EXEC   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                step_pending;
  logic                start_req;

  // Phase vector for a given state; WAIT and IDLE drive no phase.
  function automatic logic [2:0] cycle_of(input state_t s);
    case (s)
      S_FETCH:  return CYC_FETCH;
      S_DECODE: return CYC_DECODE;
      S_EXEC:   return CYC_EXEC;
      default:  return CYC_NONE;
    endcase
  endfunction

  // A new instruction may start from IDLE only while not halted.
  assign start_req = !bus.halted && (bus.run || bus.step || step_pending);

  // Next-state decode; halt beats multiply in DECODE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start_req) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (bus.is_halt)     state_next = S_IDLE;
        else if (bus.is_mul) state_next = S_WAIT;
        else                 state_next = S_EXEC;
      end
      S_WAIT:   if (wait_cnt == '0) state_next = S_EXEC;
      S_EXEC:   state_next = bus.run ? S_FETCH : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Branch select is only meaningful on the EXEC edge, so gate it with the state.
  assign bus.branch = bus.branch_req && (state == S_EXEC);

  // State register plus registered Moore outputs and bookkeeping counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      bus.cycle       <= CYC_NONE;
      bus.mul_busy    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.instr_count <= '0;
      step_pending    <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      state        <= state_next;
      bus.cycle    <= cycle_of(state_next);
      bus.mul_busy <= (state_next == S_WAIT);
      bus.busy     <= (state_next != S_IDLE);

      if (state == S_DECODE && bus.is_halt)
        bus.halted <= 1'b1;

      if (state == S_DECODE && !bus.is_halt && bus.is_mul)
        wait_cnt <= WAIT_W'(MUL_LATENCY - 1);
      else if (state == S_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - WAIT_W'(1);

      if (state == S_EXEC)
        bus.instr_count <= bus.instr_count + COUNT_WIDTH'(1);

      // Entering FETCH consumes any remembered step; steps outside IDLE are dropped.
      if (state_next == S_FETCH)
        step_pending <= 1'b0;
      else if (state == S_IDLE && bus.step && !bus.halted)
        step_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cycle_ctrl.sv
// Directed self-checking bench for the instruction-cycle sequencer.
module tb_cycle_ctrl;

  localparam int unsigned CW = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  cycle_ctrl_if #(.COUNT_WIDTH(CW)) bus ();

  cycle_ctrl #(.MUL_LATENCY(4), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.step       = 1'b0;
    bus.is_mul     = 1'b0;
    bus.is_halt    = 1'b0;
    bus.branch_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.step       = 1'b0;
    bus.is_mul     = 1'b0;
    bus.is_halt    = 1'b0;
    bus.branch_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.cycle !== 3'b000) begin n_err++; $display("FAIL reset_cycle got=%b exp=000", bus.cycle); end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.mul_busy !== 1'b0 || bus.halted !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got busy=%b mul_busy=%b halted=%b exp=0/0/0", bus.busy, bus.mul_busy, bus.halted);
    end
    n_cmp++;
    if (bus.instr_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.instr_count); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL idle_no_run got cycle=%b busy=%b exp=000/0", bus.cycle, bus.busy);
    end
  endtask

  task automatic test_run();
    logic [2:0] seq [0:5];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.cycle !== seq[i]) begin n_err++; $display("FAIL run_cycle[%0d] got=%b exp=%b", i, bus.cycle, seq[i]); end
      n_cmp++;
      if (bus.branch !== 1'b0) begin n_err++; $display("FAIL run_branch[%0d] got=%b exp=0", i, bus.branch); end
      if (i == 5) bus.run = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL run_stop got cycle=%b busy=%b exp=000/0", bus.cycle, bus.busy);
    end
    n_cmp++;
    if (bus.instr_count !== 16'd2) begin n_err++; $display("FAIL run_count got=%0d exp=2", bus.instr_count); end
  endtask

  task automatic test_mul();
    logic [2:0] seq [0:6];
    logic       mb  [0:6];
    seq = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
    mb  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    bus.run    = 1'b1;
    bus.is_mul = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.cycle !== seq[i] || bus.mul_busy !== mb[i] || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL mul_seq[%0d] got cycle=%b mul_busy=%b busy=%b exp=%b/%b/1", i, bus.cycle, bus.mul_busy, bus.busy, seq[i], mb[i]);
      end
      if (i == 6) begin
        n_cmp++;
        if (bus.instr_count !== 16'd0) begin n_err++; $display("FAIL mul_count_pre got=%0d exp=0", bus.instr_count); end
        bus.run    = 1'b0;
        bus.is_mul = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.mul_busy !== 1'b0 || bus.instr_count !== 16'd1) begin
      n_err++; $display("FAIL mul_done got cycle=%b mul_busy=%b count=%0d exp=000/0/1", bus.cycle, bus.mul_busy, bus.instr_count);
    end
  endtask

  task automatic test_step();
    do_reset();
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    n_cmp++;
    if (bus.cycle !== 3'b001) begin n_err++; $display("FAIL step_fetch got=%b exp=001", bus.cycle); end
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b010) begin n_err++; $display("FAIL step_decode got=%b exp=010", bus.cycle); end
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    n_cmp++;
    if (bus.cycle !== 3'b100) begin n_err++; $display("FAIL step_exec got=%b exp=100", bus.cycle); end
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.busy !== 1'b0 || bus.instr_count !== 16'd1) begin
      n_err++; $display("FAIL step_idle got cycle=%b busy=%b count=%0d exp=000/0/1", bus.cycle, bus.busy, bus.instr_count);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.instr_count !== 16'd1) begin
      n_err++; $display("FAIL step_ignored got cycle=%b count=%0d exp=000/1", bus.cycle, bus.instr_count);
    end
  endtask

  task automatic test_branch();
    logic br [0:5];
    br = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.run        = 1'b1;
    bus.branch_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.branch !== br[i]) begin n_err++; $display("FAIL branch[%0d] got=%b exp=%b", i, bus.branch, br[i]); end
      if (i == 5) bus.run = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.branch !== 1'b0) begin n_err++; $display("FAIL branch_idle got=%b exp=0", bus.branch); end
    bus.branch_req = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    bus.run     = 1'b1;
    bus.is_mul  = 1'b1;
    bus.is_halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b010) begin n_err++; $display("FAIL halt_decode got=%b exp=010", bus.cycle); end
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.halted !== 1'b1 || bus.mul_busy !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL halt_enter got cycle=%b halted=%b mul_busy=%b busy=%b exp=000/1/0/0", bus.cycle, bus.halted, bus.mul_busy, bus.busy);
    end
    n_cmp++;
    if (bus.instr_count !== 16'd0) begin n_err++; $display("FAIL halt_count got=%0d exp=0", bus.instr_count); end
    bus.is_mul  = 1'b0;
    bus.is_halt = 1'b0;
    bus.step    = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.cycle !== 3'b000 || bus.halted !== 1'b1) begin
        n_err++; $display("FAIL halt_sticky[%0d] got cycle=%b halted=%b exp=000/1", i, bus.cycle, bus.halted);
      end
      @(negedge clk);
    end
    do_reset();
    n_cmp++;
    if (bus.halted !== 1'b0) begin n_err++; $display("FAIL halt_clear got=%b exp=0", bus.halted); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    bus.is_mul = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.mul_busy !== 1'b1 || bus.instr_count !== 16'd1) begin
      n_err++; $display("FAIL arst_pre got mul_busy=%b count=%0d exp=1/1", bus.mul_busy, bus.instr_count);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.mul_busy !== 1'b0 || bus.busy !== 1'b0 ||
        bus.halted !== 1'b0 || bus.instr_count !== 16'd0) begin
      n_err++;
      $display("FAIL arst_async got cycle=%b mul_busy=%b busy=%b halted=%b count=%0d exp=000/0/0/0/0",
               bus.cycle, bus.mul_busy, bus.busy, bus.halted, bus.instr_count);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b000 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL arst_held got cycle=%b busy=%b exp=000/0", bus.cycle, bus.busy);
    end
    reset      = 1'b0;
    bus.is_mul = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cycle !== 3'b001) begin n_err++; $display("FAIL arst_restart got=%b exp=001", bus.cycle); end
    bus.run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_run();
    test_mul();
    test_step();
    test_branch();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
